// File: rtl/counter_ctrl.sv
// counter_ctrl: prescaled up/down counter with wrap, saturate and one-shot
// modes, synchronous load and a registered terminal-count pulse.
module counter_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ld,
    input  logic [WIDTH-1:0]      v,
    input  logic [WIDTH-1:0]      step,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic                  start,
    input  logic [PRESCALE_W-1:0] presc,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  sat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [PRESCALE_W-1:0] P_ONE = 1;
    localparam logic [WIDTH:0]        X_ONE = 1;

    state_t                r_state;
    logic [WIDTH-1:0]      r_count;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  r_tc;
    logic                  r_busy;

    logic                  w_oneshot;
    logic                  w_satmode;
    logic                  w_active;
    logic                  w_tick;
    logic [WIDTH-1:0]      w_step;
    logic [WIDTH-1:0]      w_ld_val;
    logic [WIDTH-1:0]      w_bound;
    logic [WIDTH:0]        w_cnt_x;
    logic [WIDTH:0]        w_lim_x;
    logic [WIDTH:0]        w_s_x;
    logic [WIDTH:0]        w_sum;
    logic [WIDTH:0]        w_wrap_x;
    logic [WIDTH-1:0]      w_wrap_cnt;
    logic                  w_wrap_tc;
    logic [WIDTH-1:0]      w_sat_cnt;
    logic                  w_reach;
    logic                  w_sat_tc;

    assign w_oneshot = (mode == 2'b10);
    assign w_satmode = (mode == 2'b01);

    // One-shot only lets the prescaler run while the FSM is counting.
    assign w_active = en && (!w_oneshot || r_state == S_RUN);
    assign w_tick   = w_active && (r_pcnt == presc);

    assign w_step   = (step > limit) ? limit : step;
    assign w_ld_val = (v > limit) ? limit : v;
    assign w_bound  = dir ? '0 : limit;

    assign w_cnt_x = {1'b0, r_count};
    assign w_lim_x = {1'b0, limit};
    assign w_s_x   = {1'b0, w_step};
    assign w_sum   = w_cnt_x + w_s_x;

    always_comb begin
        w_wrap_x   = '0;
        w_wrap_cnt = r_count;
        w_wrap_tc  = 1'b0;
        if (r_count > limit) begin
            w_wrap_tc  = 1'b1;
            w_wrap_cnt = dir ? limit : '0;
        end else if (!dir) begin
            if (w_sum > w_lim_x) begin
                w_wrap_tc = 1'b1;
                w_wrap_x  = w_sum - (w_lim_x + X_ONE);
            end else begin
                w_wrap_x = w_sum;
            end
            w_wrap_cnt = w_wrap_x[WIDTH-1:0];
        end else begin
            if (w_cnt_x < w_s_x) begin
                w_wrap_tc = 1'b1;
                w_wrap_x  = w_cnt_x + w_lim_x + X_ONE - w_s_x;
            end else begin
                w_wrap_x = w_cnt_x - w_s_x;
            end
            w_wrap_cnt = w_wrap_x[WIDTH-1:0];
        end
    end

    always_comb begin
        w_sat_cnt = r_count;
        if (!dir) begin
            w_sat_cnt = (w_sum > w_lim_x) ? limit : w_sum[WIDTH-1:0];
        end else if (r_count < w_step) begin
            w_sat_cnt = '0;
        end else begin
            w_sat_cnt = r_count - w_step;
        end
    end

    assign w_reach  = (w_sat_cnt == w_bound);
    assign w_sat_tc = (r_count != w_bound) && w_reach;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_pcnt  <= '0;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (!w_oneshot) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end
            if (ld) begin
                r_count <= w_ld_val;
                r_pcnt  <= '0;
                if (w_oneshot) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            end else if (w_oneshot && start) begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
                r_count <= dir ? limit : '0;
                r_pcnt  <= '0;
            end else if (w_tick) begin
                r_pcnt <= '0;
                unique case (1'b1)
                    w_oneshot: begin
                        r_count <= w_sat_cnt;
                        if (w_reach) begin
                            r_tc    <= 1'b1;
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                    w_satmode: begin
                        r_count <= w_sat_cnt;
                        r_tc    <= w_sat_tc;
                    end
                    default: begin
                        r_count <= w_wrap_cnt;
                        r_tc    <= w_wrap_tc;
                    end
                endcase
            end else if (w_active) begin
                r_pcnt <= r_pcnt + P_ONE;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = r_busy;
    assign sat   = w_satmode && (r_count == w_bound);

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios then random traffic, all
// checked each cycle against an arithmetic reference model.
module tb_counter_ctrl;

    localparam int W  = 8;
    localparam int PW = 8;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          en    = 1'b0;
    logic          ld    = 1'b0;
    logic          dir   = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  v     = '0;
    logic [W-1:0]  step  = '0;
    logic [W-1:0]  limit = '0;
    logic [1:0]    mode  = 2'b00;
    logic [PW-1:0] presc = '0;

    logic [W-1:0]  count;
    logic          tc;
    logic          busy;
    logic          sat;

    int checks = 0;
    int errors = 0;

    int m_count = 0;
    int m_pcnt  = 0;
    int m_ph    = PH_IDLE;
    bit m_tc    = 1'b0;
    bit m_busy  = 1'b0;

    always #5 clk = ~clk;

    counter_ctrl #(
        .WIDTH     (W),
        .PRESCALE_W(PW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .ld   (ld),
        .v    (v),
        .step (step),
        .limit(limit),
        .dir  (dir),
        .mode (mode),
        .start(start),
        .presc(presc),
        .count(count),
        .tc   (tc),
        .busy (busy),
        .sat  (sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_pcnt  = 0;
        m_tc    = 1'b0;
        m_busy  = 1'b0;
        m_ph    = PH_IDLE;
    endtask

    task automatic model_step();
        int lim;
        int s;
        int c;
        int n;
        int tgt;
        bit osm;
        bit active;
        bit tick;
        if (!rst) begin
            model_reset();
            return;
        end
        lim    = int'(limit);
        s      = (int'(step) < lim) ? int'(step) : lim;
        c      = m_count;
        osm    = (mode == 2'b10);
        active = en && (!osm || m_ph == PH_RUN);
        tick   = active && (m_pcnt == int'(presc));
        m_tc   = 1'b0;
        if (ld) begin
            m_count = (int'(v) > lim) ? lim : int'(v);
            m_pcnt  = 0;
            if (osm) begin
                m_ph   = PH_IDLE;
                m_busy = 1'b0;
            end
        end else if (osm && start) begin
            m_ph    = PH_RUN;
            m_busy  = 1'b1;
            m_count = dir ? lim : 0;
            m_pcnt  = 0;
        end else if (tick) begin
            m_pcnt = 0;
            if (osm || mode == 2'b01) begin
                tgt = dir ? 0 : lim;
                if (dir) n = (c - s < 0) ? 0 : c - s;
                else     n = (c + s > lim) ? lim : c + s;
                if (osm) begin
                    if (n == tgt) begin
                        m_tc   = 1'b1;
                        m_ph   = PH_DONE;
                        m_busy = 1'b0;
                    end
                end else begin
                    m_tc = (c != tgt) && (n == tgt);
                end
                m_count = n;
            end else if (c > lim) begin
                m_tc    = 1'b1;
                m_count = dir ? lim : 0;
            end else begin
                n = dir ? c - s : c + s;
                if (n < 0) begin
                    m_tc = 1'b1;
                    n    = n + lim + 1;
                end else if (n > lim) begin
                    m_tc = 1'b1;
                    n    = n - lim - 1;
                end
                m_count = n;
            end
        end else if (active) begin
            m_pcnt++;
        end
        if (!osm) begin
            m_ph   = PH_IDLE;
            m_busy = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("count", count, m_count);
        chk("tc", tc, m_tc);
        chk("busy", busy, m_busy);
        chk("sat", sat,
            (mode == 2'b01) && (m_count == (dir ? 0 : int'(limit))));
    endtask

    initial begin
        int c0;
        int exp3[5];
        exp3 = '{3, 1, 0, 0, 0};

        repeat (3) cyc();
        chk("rst_count", count, 0);
        chk("rst_tc", tc, 0);
        chk("rst_busy", busy, 0);

        // Wrap 0..9 at full rate, then async reset at count 6.
        @(negedge clk);
        rst   = 1'b1;
        mode  = 2'b00;
        limit = 8'd9;
        step  = 8'd1;
        presc = '0;
        en    = 1'b1;
        dir   = 1'b0;
        repeat (12) cyc();
        for (int k = 0; k < 12 && m_count != 6; k++) cyc();
        chk("reach6", count, 6);
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("async_count", count, 0);
        chk("async_tc", tc, 0);
        #2 rst = 1'b1;

        // Prescale by 4 with an enable gap at pcnt = 2.
        limit = 8'd255;
        presc = 8'd3;
        ld    = 1'b1;
        v     = 8'd0;
        cyc();
        ld = 1'b0;
        for (int k = 0; k < 8 && m_pcnt != 2; k++) cyc();
        c0 = m_count;
        en = 1'b0;
        repeat (5) cyc();
        chk("frozen", count, c0);
        en = 1'b1;
        cyc();
        chk("resume1", count, c0);
        cyc();
        chk("resume2", count, (c0 + 1) & 255);

        // Saturate down from 5 by 2.
        mode  = 2'b01;
        dir   = 1'b1;
        step  = 8'd2;
        presc = '0;
        ld    = 1'b1;
        v     = 8'd5;
        cyc();
        ld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("sat_seq", count, exp3[i]);
        end
        chk("sat_flag", sat, 1);

        // One-shot up to 4, hold, then re-arm.
        mode  = 2'b10;
        dir   = 1'b0;
        limit = 8'd4;
        step  = 8'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("os_init", count, 0);
        chk("os_busy", busy, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("os_seq", count, i);
        end
        chk("os_tc", tc, 1);
        chk("os_idle", busy, 0);
        repeat (3) cyc();
        chk("os_hold", count, 4);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("os_rearm", count, 0);
        chk("os_rebusy", busy, 1);

        // Load clamp coinciding with a tick, then wrap with clamped step.
        mode  = 2'b00;
        limit = 8'd100;
        ld    = 1'b1;
        v     = 8'd200;
        cyc();
        chk("ld_clamp", count, 100);
        chk("ld_tc", tc, 0);
        ld   = 1'b0;
        step = 8'd250;
        cyc();
        chk("wrap_big", count, 99);
        chk("wrap_big_tc", tc, 1);

        // Limit lowered below the count.
        ld   = 1'b1;
        v    = 8'd50;
        step = 8'd1;
        cyc();
        ld    = 1'b0;
        limit = 8'd20;
        cyc();
        chk("lim_drop", count, 0);
        chk("lim_drop_tc", tc, 1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0)
                limit = ($urandom_range(0, 3) == 0) ? 8'd255
                                                    : W'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                step = W'($urandom_range(0, 20));
            if ($urandom_range(0, 29) == 0)
                presc = PW'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                dir = ~dir;
            en    = ($urandom_range(0, 99) < 85);
            ld    = ($urandom_range(0, 99) < 4);
            v     = W'($urandom_range(0, 255));
            start = ($urandom_range(0, 99) < 6);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
